risc_dmem_dump: RTL and testbench
=================================

Name: risc_dmem_dump

Overview:
Parametrised data memory for the single-cycle RV32I core, replacing the fixed 64-word word-only RAM.
- Adds byte/half/word loads and stores with sign/zero extension, plus misalignment detection.
- Adds a debug dump engine that streams a selected word range out over a valid/ready port, so benches and debug logic no longer need hierarchical peeks into the RAM array.

Parameters:
- DEPTH, 64, number of 32-bit words (power of 2, ≥4)
- IDX_W, $clog2(DEPTH), word-index width (derived; do not override)

Ports:
- clk  in  1  system clock
- areset  in  1  asynchronous reset, active-low
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- we  in  1  store enable
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- uns  in  1  1 = zero-extend load (lbu/lhu)
- rdata  out  32  load data, extended
- misalign  out  1  access misaligned or size=11
- dump_start  in  1  pulse: begin dump
- dump_base  in  IDX_W  first word index
- dump_cnt  in  IDX_W+1  number of words (0 = none)
- dump_busy  out  1  engine active
- dbg_valid  out  1  beat valid
- dbg_ready  in  1  sink ready
- dbg_idx  out  IDX_W  word index of beat
- dbg_data  out  32  word value of beat
- dbg_last  out  1  final beat of dump

Behaviour:
- Reset (areset=0, asynchronous): all RAM words, dbg_valid, dbg_last, dump_busy, dbg_idx, and dbg_data clear to 0; FSM returns to IDLE. Reset mid-dump aborts the dump with no further beats.
- Word index = addr[IDX_W+1:2]. Upper address bits are ignored, so the address space wraps modulo DEPTH*4.
- Load path: combinational, zero latency.
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - Extension uses bit 7 or bit 15 of the selected lane unless uns=1.
- Store path: synchronous on clk rising edge when we=1 and misalign=0. Only the addressed lanes are written; other bytes are preserved.
- misalign (combinational) = (size=01 & addr[0]) | (size=10 & addr[1:0]≠0) | size=11.
  - A misaligned store writes nothing.
  - A misaligned load returns 0.
- Dump FSM states: IDLE, LOAD, SEND.
  - IDLE: on dump_start=1 with dump_cnt≠0, latch ptr=dump_base and remaining=dump_cnt, then go to LOAD. dump_start with dump_cnt=0 is ignored.
  - LOAD (1 cycle): dbg_data<=ram[ptr], dbg_idx<=ptr, dbg_last<=(remaining==1), dbg_valid<=1, then go to SEND.
  - SEND: hold all dbg_* outputs stable while dbg_valid=1 and dbg_ready=0. On the handshake (valid&ready):
    - if dbg_last: clear dbg_valid and dbg_last, go to IDLE;
    - else: ptr<=ptr+1 (wraps modulo DEPTH), remaining-=1, clear dbg_valid, go to LOAD.
  - Throughput: 1 beat per 2 cycles maximum.
- dump_busy = 1 in LOAD and SEND.
- dump_start while busy is ignored.
- Snapshot rule: dbg_data is the value at the LOAD edge.
  - A CPU store to the same word in the LOAD cycle is not visible in that beat (read-before-write).
  - A store during SEND does not alter the held beat.
- CPU loads and stores are never stalled by the dump engine.

Optional Feature:
DMEM_DUMP_EN
- Defined: dump engine present as specified.
- Undefined: FSM not built. dump_busy, dbg_valid, dbg_last, dbg_idx, and dbg_data are tied to 0; dump_start, dump_base, dump_cnt, and dbg_ready are ignored. The memory behaviour is otherwise identical.

Test Plan:
- Store/load widths: reset; sw 0x80FF7F01 to addr 8. Then:
  - lb at addr 8 → 0x00000001;
  - lb at addr 11 → 0xFFFFFF80;
  - lbu at addr 11 → 0x00000080;
  - lh at addr 10 → 0xFFFF80FF;
  - lhu at addr 10 → 0x000080FF.
- Partial stores: sw 0x11223344 to addr 4; sb 0xAA to addr 6; sh 0xBEEF to addr 4 → lw at addr 4 = 0x11AABEEF.
- Misalignment:
  - sh to addr 5 → misalign=1 and memory unchanged;
  - lw at addr 2 → misalign=1, rdata=0;
  - size=11 → misalign=1.
- Wrap and dump (DMEM_DUMP_EN defined, DEPTH=64, dbg_ready=1): sw i+100 to word i for all i; dump_base=62, dump_cnt=4 → beats idx 62,63,0,1 with data 162,163,100,101; dbg_last only on idx 1; dump_busy drops afterwards.
- Backpressure and snapshot: hold dbg_ready=0 for 5 cycles on the first beat → dbg_* outputs stable. A store to that word during the stall leaves dbg_data at its old value. Raising dbg_ready resumes the dump with no beat lost or duplicated.
- Reset mid-dump: drop areset during SEND → dbg_valid=0, dump_busy=0, RAM all 0. After release, no beats appear until a new dump_start; dump_start with dump_cnt=0 never raises dump_busy.

Source files
------------

// File: rtl/risc_dmem_dump.sv
// Byte/half/word data memory for the single-cycle RV32I core with an optional
// debug dump engine that streams a word range out over valid/ready (DMEM_DUMP_EN).
module risc_dmem_dump #(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              areset,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   output logic [31:0]       rdata,
   output logic              misalign,
   input  logic              dump_start,
   input  logic [IDX_W-1:0]  dump_base,
   input  logic [IDX_W:0]    dump_cnt,
   output logic              dump_busy,
   output logic              dbg_valid,
   input  logic              dbg_ready,
   output logic [IDX_W-1:0]  dbg_idx,
   output logic [31:0]       dbg_data,
   output logic              dbg_last
);

   logic [31:0]      ram [DEPTH];
   logic [IDX_W-1:0] widx;
   logic [31:0]      word;
   logic [7:0]       blane;
   logic [15:0]      hlane;
   logic [3:0]       be;
   logic [31:0]      wd;
   logic             unused_addr;

   // Upper address bits are dropped so the address space wraps modulo DEPTH*4.
   assign widx        = addr[IDX_W+1:2];
   assign word        = ram[widx];
   assign unused_addr = ^addr[31:IDX_W+2];

   assign misalign = ((size == 2'b01) & addr[0]) |
                     ((size == 2'b10) & (addr[1:0] != 2'b00)) |
                     (size == 2'b11);

   always_comb begin
      blane = 8'h00;
      hlane = addr[1] ? word[31:16] : word[15:0];
      rdata = 32'h0;
      case (addr[1:0])
         2'b00:   blane = word[7:0];
         2'b01:   blane = word[15:8];
         2'b10:   blane = word[23:16];
         default: blane = word[31:24];
      endcase
      if (!misalign) begin
         case (size)
            2'b00:   rdata = {{24{blane[7] & ~uns}}, blane};
            2'b01:   rdata = {{16{hlane[15] & ~uns}}, hlane};
            2'b10:   rdata = word;
            default: rdata = 32'h0;
         endcase
      end
   end

   // Replicate store data across lanes so a byte enable alone picks what lands.
   always_comb begin
      be = 4'b0000;
      wd = wdata;
      case (size)
         2'b00: begin
            wd = {4{wdata[7:0]}};
            be = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            wd = {2{wdata[15:0]}};
            be = addr[1] ? 4'b1100 : 4'b0011;
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram[i] <= 32'h0;
         end
      end else if (we && !misalign) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               ram[widx][b*8 +: 8] <= wd[b*8 +: 8];
            end
         end
      end
   end

`ifdef DMEM_DUMP_EN
   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0]   remaining;

   // LOAD samples ram[ptr] with the pre-edge value, so a same-cycle store is not seen.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         dump_busy <= 1'b0;
         dbg_valid <= 1'b0;
         dbg_last  <= 1'b0;
         dbg_idx   <= '0;
         dbg_data  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (dump_start && (dump_cnt != '0)) begin
                  ptr       <= dump_base;
                  remaining <= dump_cnt;
                  dump_busy <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               dbg_data  <= ram[ptr];
               dbg_idx   <= ptr;
               dbg_last  <= (remaining == 1);
               dbg_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (dbg_valid && dbg_ready) begin
                  dbg_valid <= 1'b0;
                  if (dbg_last) begin
                     dbg_last  <= 1'b0;
                     dump_busy <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     ptr       <= ptr + 1'b1;
                     remaining <= remaining - 1'b1;
                     state     <= LOAD;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               dump_busy <= 1'b0;
               dbg_valid <= 1'b0;
               dbg_last  <= 1'b0;
            end
         endcase
      end
   end
`else
   logic unused_dump;

   assign unused_dump = ^{dump_start, dump_base, dump_cnt, dbg_ready};
   assign dump_busy   = 1'b0;
   assign dbg_valid   = 1'b0;
   assign dbg_last    = 1'b0;
   assign dbg_idx     = '0;
   assign dbg_data    = 32'h0;
`endif

endmodule

// File: tb/tb_risc_dmem_dump.sv
// Scoreboard bench for risc_dmem_dump: load checks and dump beats are queued
// by the stimulus and popped by a monitor on the falling edge.
module tb_risc_dmem_dump;

   localparam int DEPTH = 64;
   localparam int IDX_W = 6;

   logic              clk;
   logic              areset;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              we;
   logic [1:0]        size;
   logic              uns;
   logic [31:0]       rdata;
   logic              misalign;
   logic              dump_start;
   logic [IDX_W-1:0]  dump_base;
   logic [IDX_W:0]    dump_cnt;
   logic              dump_busy;
   logic              dbg_valid;
   logic              dbg_ready;
   logic [IDX_W-1:0]  dbg_idx;
   logic [31:0]       dbg_data;
   logic              dbg_last;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      string       name;
   } load_exp_t;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
      logic             last;
   } beat_exp_t;

   load_exp_t load_q[$];
   beat_exp_t dump_q[$];
   logic      load_req;
   int        checks;
   int        failures;

   risc_dmem_dump #(.DEPTH(DEPTH)) dut (
      .clk(clk), .areset(areset), .addr(addr), .wdata(wdata), .we(we),
      .size(size), .uns(uns), .rdata(rdata), .misalign(misalign),
      .dump_start(dump_start), .dump_base(dump_base), .dump_cnt(dump_cnt),
      .dump_busy(dump_busy), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_last(dbg_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops expected loads on request and expected beats on handshake.
   always @(negedge clk) begin
      load_exp_t le;
      beat_exp_t be;
      if (load_req) begin
         checks++;
         if (load_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL load_queue_empty: rdata=%h with no expectation", rdata);
         end else begin
            le = load_q.pop_front();
            if (rdata !== le.rdata || misalign !== le.mis) begin
               failures++;
               $display("[TB] FAIL %s: got rdata=%h misalign=%b, expected rdata=%h misalign=%b",
                        le.name, rdata, misalign, le.rdata, le.mis);
            end
         end
      end
      if (areset && dbg_valid) begin
         checks++;
         if (dump_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_beat: idx=%0d data=%h last=%b", dbg_idx, dbg_data, dbg_last);
         end else begin
            be = dump_q[0];
            if (dbg_idx !== be.idx || dbg_data !== be.data || dbg_last !== be.last) begin
               failures++;
               $display("[TB] FAIL beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                        dbg_idx, dbg_data, dbg_last, be.idx, be.data, be.last);
            end
            if (dbg_ready) be = dump_q.pop_front();
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      addr = a; wdata = d; size = s; uns = 1'b0; we = 1'b1;
      cycle();
      we = 1'b0;
   endtask

   task automatic check_output(input logic [31:0] a, input logic [1:0] s, input logic u,
                               input logic [31:0] exp, input logic em, input string nm);
      load_exp_t le;
      addr = a; size = s; uns = u; we = 1'b0;
      le.rdata = exp; le.mis = em; le.name = nm;
      load_q.push_back(le);
      load_req = 1'b1;
      cycle();
      load_req = 1'b0;
   endtask

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic push_beat(input int idx, input logic [31:0] d, input logic l);
      beat_exp_t be;
      be.idx = idx[IDX_W-1:0]; be.data = d; be.last = l;
      dump_q.push_back(be);
   endtask

   task automatic start_dump(input int base, input int cnt);
      dump_base = base[IDX_W-1:0];
      dump_cnt = cnt[IDX_W:0];
      dump_start = 1'b1;
      cycle();
      dump_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while (dump_busy && n < budget) begin
         cycle();
         n++;
      end
      check_val(nm, {31'd0, dump_busy}, 32'd0);
   endtask

   initial begin
      load_exp_t le;
      checks = 0; failures = 0; load_req = 1'b0;
      areset = 1'b0; addr = 0; wdata = 0; we = 0; size = 2'b10; uns = 0;
      dump_start = 0; dump_base = 0; dump_cnt = 0; dbg_ready = 0;

      repeat (2) @(posedge clk);
      #1;
      check_val("reset_dbg_valid", {31'd0, dbg_valid}, 32'd0);
      check_val("reset_dump_busy", {31'd0, dump_busy}, 32'd0);
      check_val("reset_dbg_last", {31'd0, dbg_last}, 32'd0);
      check_val("reset_dbg_idx", {26'd0, dbg_idx}, 32'd0);
      check_val("reset_dbg_data", dbg_data, 32'd0);
      areset = 1'b1;
      cycle();
      check_output(32'd8, 2'b10, 1'b0, 32'h0, 1'b0, "reset_ram_lw8");

      $display("[TB] load widths");
      apply_store(32'd8, 32'h80FF7F01, 2'b10);
      check_output(32'd8,  2'b10, 1'b0, 32'h80FF7F01, 1'b0, "lw8");
      check_output(32'd8,  2'b00, 1'b0, 32'h00000001, 1'b0, "lb8");
      check_output(32'd9,  2'b00, 1'b0, 32'h0000007F, 1'b0, "lb9");
      check_output(32'd11, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, "lb11");
      check_output(32'd11, 2'b00, 1'b1, 32'h00000080, 1'b0, "lbu11");
      check_output(32'd10, 2'b00, 1'b0, 32'hFFFFFFFF, 1'b0, "lb10");
      check_output(32'd10, 2'b01, 1'b0, 32'hFFFF80FF, 1'b0, "lh10");
      check_output(32'd10, 2'b01, 1'b1, 32'h000080FF, 1'b0, "lhu10");
      check_output(32'd8,  2'b01, 1'b0, 32'h00007F01, 1'b0, "lh8");
      check_output(32'd8 + 32'd256, 2'b10, 1'b0, 32'h80FF7F01, 1'b0, "lw_wrap264");

      $display("[TB] partial stores");
      apply_store(32'd4, 32'h11223344, 2'b10);
      apply_store(32'd6, 32'h000000AA, 2'b00);
      check_output(32'd4, 2'b10, 1'b0, 32'h11AA3344, 1'b0, "after_sb6");
      apply_store(32'd4, 32'h0000BEEF, 2'b01);
      check_output(32'd4, 2'b10, 1'b0, 32'h11AABEEF, 1'b0, "after_sh4");

      $display("[TB] misalignment");
      addr = 32'd5; wdata = 32'h00005555; size = 2'b01; uns = 1'b0; we = 1'b1;
      le.rdata = 32'h0; le.mis = 1'b1; le.name = "sh5_misalign";
      load_q.push_back(le);
      load_req = 1'b1;
      cycle();
      load_req = 1'b0; we = 1'b0;
      check_output(32'd4, 2'b10, 1'b0, 32'h11AABEEF, 1'b0, "sh5_no_write");
      check_output(32'd2, 2'b10, 1'b0, 32'h0, 1'b1, "lw2_misalign");
      check_output(32'd0, 2'b11, 1'b0, 32'h0, 1'b1, "size11_misalign");
      check_output(32'd9, 2'b01, 1'b0, 32'h0, 1'b1, "lh9_misalign");

`ifdef DMEM_DUMP_EN
      $display("[TB] wrap dump");
      for (int i = 0; i < DEPTH; i++) apply_store(i * 4, i + 100, 2'b10);
      dbg_ready = 1'b1;
      push_beat(62, 32'd162, 1'b0);
      push_beat(63, 32'd163, 1'b0);
      push_beat(0, 32'd100, 1'b0);
      push_beat(1, 32'd101, 1'b1);
      start_dump(62, 4);
      check_val("busy_after_start", {31'd0, dump_busy}, 32'd1);
      wait_idle(50, "wrap_dump_timeout");
      check_val("wrap_dump_drained", dump_q.size(), 32'd0);

      $display("[TB] snapshot in LOAD cycle");
      push_beat(20, 32'd120, 1'b1);
      start_dump(20, 1);
      apply_store(32'd80, 32'h12345678, 2'b10);
      wait_idle(20, "load_snap_timeout");
      check_val("load_snap_drained", dump_q.size(), 32'd0);
      check_output(32'd80, 2'b10, 1'b0, 32'h12345678, 1'b0, "lw80_after_dump");

      $display("[TB] backpressure");
      dbg_ready = 1'b0;
      push_beat(10, 32'd110, 1'b0);
      push_beat(11, 32'd111, 1'b1);
      start_dump(10, 2);
      cycle();
      check_val("stall_valid", {31'd0, dbg_valid}, 32'd1);
      cycle();
      apply_store(32'd40, 32'hDEADBEEF, 2'b10);
      repeat (2) cycle();
      dbg_ready = 1'b1;
      wait_idle(30, "stall_dump_timeout");
      check_val("stall_dump_drained", dump_q.size(), 32'd0);
      check_output(32'd40, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, "lw40_after_stall");

      dbg_ready = 1'b0;
      push_beat(0, 32'd100, 1'b0);
      start_dump(0, 3);
      repeat (2) cycle();
      check_val("pre_reset_busy", {31'd0, dump_busy}, 32'd1);
`else
      $display("[TB] dump engine absent");
      dbg_ready = 1'b1;
      start_dump(0, 4);
      repeat (6) begin
         check_val("tied_off", {dump_busy, dbg_valid, dbg_last, dbg_idx, dbg_data[22:0]}, 32'd0);
         cycle();
      end
`endif

      $display("[TB] reset mid-operation");
      areset = 1'b0;
      #2;
      check_val("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
      check_val("rst_dump_busy", {31'd0, dump_busy}, 32'd0);
      check_val("rst_dbg_last", {31'd0, dbg_last}, 32'd0);
      check_val("rst_dbg_data", dbg_data, 32'd0);
      dump_q.delete();
      cycle();
      areset = 1'b1;
      for (int i = 0; i < DEPTH; i++) check_output(i * 4, 2'b10, 1'b0, 32'h0, 1'b0, "ram_cleared");
      dbg_ready = 1'b1;
      repeat (10) cycle();
      start_dump(5, 0);
      repeat (4) begin
         check_val("cnt0_no_busy", {31'd0, dump_busy}, 32'd0);
         cycle();
      end
      check_val("load_q_drained", load_q.size(), 32'd0);
      check_val("dump_q_empty", dump_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
